// File: rtl/pulse_meter_pkg.sv
// Shared types and defaults for the pulse width meter.
//
// Contents:
//   CNT_W_DEF      - default width of the pulse-width counter
//   FIFO_DEPTH_DEF - default record buffer depth
//   pulse_rec_t    - record layout {sat, width}; sat sits above width, which is
//                    also how records of non-default widths are packed in the FIFO
package pulse_meter_pkg;

    localparam int unsigned CNT_W_DEF      = 8;
    localparam int unsigned FIFO_DEPTH_DEF = 4;

    typedef struct packed {
        logic                 sat;
        logic [CNT_W_DEF-1:0] width;
    } pulse_rec_t;

endpackage

// File: rtl/pulse_width_meter_if.sv
// Record output channel of the pulse width meter (valid/ready handshake).
//
// Signals:
//   out_valid  - a record is available at the head of the buffer
//   out_ready  - consumer accepts the record this cycle
//   out_width  - pulse length in cycles
//   out_sat    - width count saturated
//   out_single - one-cycle pulse (width == 1 and not saturated)
// Modports: master (meter side), slave (consumer side).
interface pulse_width_meter_if #(
    parameter int unsigned CNT_W = 8
) ();

    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_width;
    logic             out_sat;
    logic             out_single;

    modport master (
        output out_valid,
        output out_width,
        output out_sat,
        output out_single,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_width,
        input  out_sat,
        input  out_single,
        output out_ready
    );

endinterface

// File: rtl/pulse_rec_fifo.sv
// Synchronous FIFO holding pulse records.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (clears pointers only)
//   push        - write push_data; accepted when not full, or when full and
//                 popping in the same cycle (the pop frees the slot first)
//   push_data   - record to write
//   pop         - remove the head entry; ignored when empty
//   full, empty - occupancy flags
//   head        - oldest entry, valid only while !empty
//
// DEPTH must be a power of two and at least 2.
module pulse_rec_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);

    // One extra pointer bit tells full from empty when the indices match.
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign rd_en = pop & ~empty;
    // When full, the slot being written is the one being read out this cycle.
    assign wr_en = push & (~full | rd_en);

    assign head = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/pulse_width_meter.sv
// Pulse width meter: measures how many cycles the level `a` stays high and
// queues one {width, sat} record per completed pulse.
//
// Ports:
//   clk       - clock, all state changes on its rising edge
//   rst_n     - asynchronous active-low reset; a pulse in progress is discarded
//   a         - monitored level, synchronous to clk
//   busy      - high while a pulse is being measured (a_r | a)
//   out       - record channel (pulse_width_meter_if.master)
//   drop_cnt  - saturating count of records dropped on a full buffer; present
//               only when PULSE_METER_DROP_CNT_EN is defined
//
// Configuration macro: PULSE_METER_DROP_CNT_EN (drop counter port and logic).
// Without it, records arriving at a full buffer are dropped silently.
module pulse_width_meter
    import pulse_meter_pkg::*;
#(
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                a,
    output logic                busy,
    pulse_width_meter_if.master out
`ifdef PULSE_METER_DROP_CNT_EN
    ,
    output logic [7:0]          drop_cnt
`endif
);

    localparam int unsigned     REC_W   = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             a_r;
    logic [CNT_W-1:0] cnt;
    logic             sat;
    logic             rise;
    logic             fall;
    logic             high;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [REC_W-1:0] fifo_head;
    logic [CNT_W-1:0] head_width;
    logic             head_sat;

    assign rise = a & ~a_r;
    assign fall = ~a & a_r;
    assign high = a & a_r;
    assign busy = a_r | a;

    // The counter holds its value through the fall cycle so the record pushed
    // at the end of that cycle carries the full high-time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= 1'b0;
            cnt <= '0;
            sat <= 1'b0;
        end else begin
            a_r <= a;
            if (rise) begin
                cnt <= CNT_ONE;
                sat <= 1'b0;
            end else if (high) begin
                if (cnt == CNT_MAX) begin
                    sat <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_ONE;
                end
            end
        end
    end

    assign fifo_pop = out.out_valid & out.out_ready;

    pulse_rec_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fall),
        .push_data ({sat, cnt}),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign {head_sat, head_width} = fifo_head;

    // Head fields are forced to zero while empty so the outputs are defined
    // after reset even though the storage itself is not cleared.
    assign out.out_valid  = ~fifo_empty;
    assign out.out_width  = fifo_empty ? '0 : head_width;
    assign out.out_sat    = ~fifo_empty & head_sat;
    assign out.out_single = ~fifo_empty & ~head_sat & (head_width == CNT_ONE);

`ifdef PULSE_METER_DROP_CNT_EN
    logic       drop;
    logic [7:0] drop_cnt_q;

    assign drop = fall & fifo_full & ~fifo_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= 8'd0;
        end else if (drop && (drop_cnt_q != 8'hff)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    logic unused_fifo_full;
    assign unused_fifo_full = fifo_full;
`endif

endmodule

// File: tb/tb_pulse_width_meter.sv
`timescale 1ns/1ps
module tb_pulse_width_meter;
    import pulse_meter_pkg::*;

    localparam int unsigned DEPTH = FIFO_DEPTH_DEF;
    localparam int unsigned W     = CNT_W_DEF;
    localparam int unsigned W3    = 3;
    localparam int unsigned MAX8  = (1 << W) - 1;
    localparam int unsigned MAX3  = (1 << W3) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic a     = 1'b0;
    logic busy;
    logic busy3;

    pulse_width_meter_if #(.CNT_W(W))  oif  ();
    pulse_width_meter_if #(.CNT_W(W3)) oif3 ();

`ifdef PULSE_METER_DROP_CNT_EN
    logic [7:0] drop_cnt;
    logic [7:0] drop_cnt3;
`endif

    always #5 clk = ~clk;

    pulse_width_meter #(.CNT_W(W), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .busy     (busy),
        .out      (oif)
`ifdef PULSE_METER_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    pulse_width_meter #(.CNT_W(W3), .FIFO_DEPTH(DEPTH)) dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .busy     (busy3),
        .out      (oif3)
`ifdef PULSE_METER_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt3)
`endif
    );

    // Reference model: completed pulses become records in bounded queues.
    typedef struct {
        int unsigned width;
        bit          sat;
    } rec_t;

    rec_t        q[$];
    rec_t        q3[$];
    bit          m_prev;
    int unsigned run;
    int unsigned drops;

    int checks = 0;
    int errors = 0;

    logic         s_valid, s_sat, s_single;
    logic [W-1:0] s_width;
    logic         s3_valid, s3_sat, s3_single;
    logic [W3-1:0] s3_width;
    int           valid_cycles;
    int           busy_cycles;

    function automatic rec_t make_rec(input int unsigned len, input int unsigned max);
        rec_t r;
        r.sat   = (len > max);
        r.width = r.sat ? max : len;
        return r;
    endfunction

    task automatic model_clear();
        q.delete();
        q3.delete();
        m_prev = 1'b0;
        run    = 0;
        drops  = 0;
    endtask

    // Must be called right after a posedge (tick leaves time there).
    task automatic apply_reset();
        #2 rst_n = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the model.
    task automatic tick(input logic av, input logic rv);
        rec_t r;
        bit   pop8;
        @(negedge clk);
        a              = av;
        oif.out_ready  = rv;
        oif3.out_ready = 1'b1;
        #1;
        s_valid   = oif.out_valid;
        s_width   = oif.out_width;
        s_sat     = oif.out_sat;
        s_single  = oif.out_single;
        s3_valid  = oif3.out_valid;
        s3_width  = oif3.out_width;
        s3_sat    = oif3.out_sat;
        s3_single = oif3.out_single;
        if (s_valid === 1'b1) valid_cycles++;
        if (busy === 1'b1) busy_cycles++;

        checks++;
        if (busy !== (av | m_prev) || busy3 !== (av | m_prev)) begin
            $display("FAIL busy: got %b/%b want %b", busy, busy3, av | m_prev);
            errors++;
        end
        checks++;
        if (oif.out_valid !== (q.size() > 0) || oif3.out_valid !== (q3.size() > 0)) begin
            $display("FAIL out_valid: got %b/%b want %b/%b", oif.out_valid, oif3.out_valid,
                     q.size() > 0, q3.size() > 0);
            errors++;
        end
        if (q.size() > 0) begin
            checks++;
            if (oif.out_width !== W'(q[0].width) || oif.out_sat !== q[0].sat ||
                oif.out_single !== (q[0].width == 1 && !q[0].sat)) begin
                $display("FAIL record: got w=%0d s=%b 1=%b want w=%0d s=%b", oif.out_width,
                         oif.out_sat, oif.out_single, q[0].width, q[0].sat);
                errors++;
            end
        end
        if (q3.size() > 0) begin
            checks++;
            if (oif3.out_width !== W3'(q3[0].width) || oif3.out_sat !== q3[0].sat ||
                oif3.out_single !== (q3[0].width == 1 && !q3[0].sat)) begin
                $display("FAIL record_w3: got w=%0d s=%b 1=%b want w=%0d s=%b", oif3.out_width,
                         oif3.out_sat, oif3.out_single, q3[0].width, q3[0].sat);
                errors++;
            end
        end
`ifdef PULSE_METER_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 8'((drops > 255) ? 255 : drops) || drop_cnt3 !== 8'd0) begin
            $display("FAIL drop_cnt: got %0d/%0d want %0d/0", drop_cnt, drop_cnt3, drops);
            errors++;
        end
`endif

        @(posedge clk);
        pop8 = (q.size() > 0) && rv;
        if (pop8) void'(q.pop_front());
        if (q3.size() > 0) void'(q3.pop_front());
        if (av) begin
            run = m_prev ? run + 1 : 1;
        end else if (m_prev) begin
            r = make_rec(run, MAX8);
            if (q.size() < DEPTH) q.push_back(r);
            else drops++;
            r = make_rec(run, MAX3);
            if (q3.size() < DEPTH) q3.push_back(r);
        end
        m_prev = av;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (oif.out_valid !== 1'b0 || oif.out_width !== '0 || oif.out_sat !== 1'b0 ||
            oif.out_single !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL reset_outputs: got v=%b w=%0d s=%b 1=%b busy=%b want all 0",
                     oif.out_valid, oif.out_width, oif.out_sat, oif.out_single, busy);
            errors++;
        end
        a = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b1 || oif.out_valid !== 1'b0) begin
            $display("FAIL reset_busy_follows_a: got busy=%b v=%b want 1/0", busy, oif.out_valid);
            errors++;
        end
        a = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_single();
        tick(1'b0, 1'b1);
        valid_cycles = 0;
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        checks++;
        if (s_valid !== 1'b1 || s_width !== W'(1) || s_single !== 1'b1 || s_sat !== 1'b0) begin
            $display("FAIL single_record: got v=%b w=%0d 1=%b s=%b want 1/1/1/0",
                     s_valid, s_width, s_single, s_sat);
            errors++;
        end
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        checks++;
        if (valid_cycles !== 1) begin
            $display("FAIL single_valid_cycles: got %0d want 1", valid_cycles);
            errors++;
        end
    endtask

    task automatic test_long();
        tick(1'b0, 1'b1);
        busy_cycles = 0;
        repeat (5) tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        checks++;
        if (s_valid !== 1'b1 || s_width !== W'(5) || s_single !== 1'b0) begin
            $display("FAIL long_record: got v=%b w=%0d 1=%b want 1/5/0", s_valid, s_width, s_single);
            errors++;
        end
        tick(1'b0, 1'b1);
        checks++;
        if (busy_cycles !== 6) begin
            $display("FAIL long_busy_cycles: got %0d want 6", busy_cycles);
            errors++;
        end
    endtask

    task automatic test_sat();
        tick(1'b0, 1'b1);
        repeat (10) tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        checks++;
        if (s3_valid !== 1'b1 || s3_width !== W3'(7) || s3_sat !== 1'b1 || s3_single !== 1'b0) begin
            $display("FAIL sat_record: got v=%b w=%0d s=%b 1=%b want 1/7/1/0",
                     s3_valid, s3_width, s3_sat, s3_single);
            errors++;
        end
        checks++;
        if (s_width !== W'(10) || s_sat !== 1'b0) begin
            $display("FAIL nosat_record: got w=%0d s=%b want 10/0", s_width, s_sat);
            errors++;
        end
        tick(1'b0, 1'b1);
    endtask

    task automatic test_drop();
        apply_reset();
        repeat (6) begin
            tick(1'b1, 1'b0);
            tick(1'b0, 1'b0);
        end
        tick(1'b0, 1'b0);
        checks++;
        if (s_valid !== 1'b1) begin
            $display("FAIL drop_held_valid: got %b want 1", s_valid);
            errors++;
        end
`ifdef PULSE_METER_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 8'd2) begin
            $display("FAIL drop_count: got %0d want 2", drop_cnt);
            errors++;
        end
`endif
        valid_cycles = 0;
        repeat (4) begin
            tick(1'b0, 1'b1);
            checks++;
            if (s_valid !== 1'b1 || s_width !== W'(1)) begin
                $display("FAIL drain_width: got v=%b w=%0d want 1/1", s_valid, s_width);
                errors++;
            end
        end
        tick(1'b0, 1'b1);
        checks++;
        if (valid_cycles !== 4 || s_valid !== 1'b0) begin
            $display("FAIL drain_count: got %0d (v=%b) want 4 (v=0)", valid_cycles, s_valid);
            errors++;
        end
    endtask

    task automatic test_full_push_pop();
        int unsigned widths[4] = '{1, 2, 3, 1};
        apply_reset();
        foreach (widths[i]) begin
            repeat (widths[i]) tick(1'b1, 1'b0);
            tick(1'b0, 1'b0);
        end
        repeat (2) tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        valid_cycles = 0;
        repeat (5) tick(1'b0, 1'b1);
        checks++;
        if (valid_cycles !== 4) begin
            $display("FAIL full_push_pop_count: got %0d want 4", valid_cycles);
            errors++;
        end
`ifdef PULSE_METER_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 8'd0) begin
            $display("FAIL full_push_pop_drops: got %0d want 0", drop_cnt);
            errors++;
        end
`endif
    endtask

    task automatic test_reset_mid();
        apply_reset();
        tick(1'b0, 1'b1);
        valid_cycles = 0;
        repeat (4) tick(1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (oif.out_valid !== 1'b0 || busy !== 1'b1 || oif.out_width !== '0) begin
            $display("FAIL reset_mid_outputs: got v=%b busy=%b w=%0d want 0/1/0",
                     oif.out_valid, busy, oif.out_width);
            errors++;
        end
        model_clear();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        checks++;
        if (s_valid !== 1'b1 || s_width !== W'(3)) begin
            $display("FAIL reset_mid_record: got v=%b w=%0d want 1/3", s_valid, s_width);
            errors++;
        end
        tick(1'b0, 1'b1);
        checks++;
        if (valid_cycles !== 1) begin
            $display("FAIL reset_mid_records: got %0d want 1", valid_cycles);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        tick(1'b0, 1'b1);
        valid_cycles = 0;
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        checks++;
        if (valid_cycles !== 2) begin
            $display("FAIL back_to_back_records: got %0d want 2", valid_cycles);
            errors++;
        end
    endtask

    task automatic test_random();
        int unsigned hi;
        int unsigned lo;
        for (int n = 0; n < 60; n++) begin
            hi = $urandom_range(1, 12);
            lo = $urandom_range(1, 4);
            repeat (hi) tick(1'b1, ($urandom_range(0, 9) < 6));
            repeat (lo) tick(1'b0, ($urandom_range(0, 9) < 6));
        end
        repeat (DEPTH + 2) tick(1'b0, 1'b1);
    endtask

    initial begin
        oif.out_ready  = 1'b0;
        oif3.out_ready = 1'b1;
        valid_cycles   = 0;
        busy_cycles    = 0;
        test_reset();
        test_single();
        test_long();
        test_sat();
        test_drop();
        test_full_push_pop();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_width_meter.md
PULSE_WIDTH_METER -- requirements
Module: pulse_width_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the pulse-width count.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, record buffer depth; a power of two and at least 2.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port a, input, 1, monitored level, synchronous to clk.
REQ-006 SHALL have port busy, output, 1, high while a pulse is being measured.
REQ-007 SHALL have port out_valid, output, 1, a record is available.
REQ-008 SHALL have port out_ready, input, 1, the consumer accepts the record.
REQ-009 SHALL have port out_width, output, CNT_W, the pulse length in cycles.
REQ-010 SHALL have port out_sat, output, 1, the width count saturated.
REQ-011 SHALL have port out_single, output, 1, marks a one-cycle (010) pulse: out_width == 1 and out_sat == 0.
REQ-012 SHALL have port drop_cnt, output, 8, the count of dropped records; present only under PULSE_METER_DROP_CNT_EN.

Function
REQ-013 SHALL register a as a_r every cycle; rise = a & ~a_r, fall = ~a & a_r.
REQ-014 SHALL load the width counter with 1 on rise, increment it each cycle while a & a_r, and hold it otherwise.
REQ-015 SHALL saturate the width counter at 2^CNT_W-1 and set the sat flag, with no wrap-around.
REQ-016 SHALL push record {width, sat} into the FIFO at the clock edge ending a fall cycle.
- Result: width equals the number of cycles a was high.
REQ-017 SHALL assert out_valid in the cycle after the push when the FIFO was empty; there is no combinational bypass.
REQ-018 SHALL pop on out_valid & out_ready; out_width, out_sat and out_single SHALL be driven from the FIFO head.
REQ-019 SHALL hold out_* stable while out_valid & ~out_ready.
REQ-020 SHALL accept a push together with a pop when the FIFO is full; the pop frees the slot first.
REQ-021 SHALL drop the record on a push when the FIFO is full with no pop; FIFO contents are unchanged.
REQ-022 SHALL assert busy = a_r | a.
REQ-023 SHALL treat the sequence 1,0,1 as two independent pulses with no lost records.
REQ-024 SHALL NOT emit a record for a pulse still high; it is reported only on its fall.

Reset
REQ-025 SHALL, on rst_n low, immediately clear a_r, the width counter, sat, the FIFO pointers and drop_cnt.
- Result: out_valid=0, busy=a, out_width=0, out_sat=0, out_single=0.
REQ-026 SHALL discard a pulse in progress at reset.
- If a is high at reset release, the first cycle counts as a rise and a new pulse starts.

Configuration
REQ-027 SHALL, when PULSE_METER_DROP_CNT_EN is defined, provide drop_cnt, which increments on each drop and saturates at 255.
REQ-028 SHALL, when PULSE_METER_DROP_CNT_EN is undefined, omit the drop_cnt port and its logic; drops are silent.

Structure
REQ-029 SHALL define, in package pulse_meter_pkg:
- typedef pulse_rec_t, a packed struct {sat, width};
- the default constants CNT_W_DEF and FIFO_DEPTH_DEF.
REQ-030 SHALL instantiate sub-module pulse_rec_fifo, a synchronous FIFO with parameterised width and depth, exposing push, pop, full, empty and head.

Verification
REQ-031 SHALL cover a = 0,1,0 with out_ready=1:
- one record, width=1, single=1, sat=0;
- out_valid high exactly one cycle, two cycles after the rise cycle.
REQ-032 SHALL cover a high 5 cycles, then low: record width=5, single=0, busy high for 6 cycles (the 5 high cycles plus the fall cycle).
REQ-033 SHALL cover CNT_W=3 with a high 10 cycles: record width=7, sat=1, single=0.
REQ-034 SHALL cover out_ready=0 with 6 one-cycle pulses at depth 4:
- 4 records are held and 2 are dropped, and drop_cnt=2 under the macro;
- raising out_ready then drains widths 1,1,1,1 in order.
REQ-035 SHALL cover a full FIFO receiving a push and a pop in the same cycle: the record is accepted and the count stays 4.
REQ-036 SHALL cover rst_n asserted mid-pulse while a stays high:
- no record is produced for the old pulse;
- after release with a held 3 more cycles then low, one record with width=3.
